// File: rtl/anc_seq_pkg.sv
// Shared types and defaults for the ANC per-sample sequencer.
package anc_seq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int STATE_W   = 3;

    // Encoded values are visible on state_out for ILA/LED debug.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_LP_WAIT = 3'd1,
        S_ADAPT   = 3'd2,
        S_FILTER  = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

endpackage

// File: rtl/anc_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at MAX and never wraps.
module anc_sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment holds once MAX is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/anc_sequencer.sv
// Per-sample scheduler: lowpass pair -> NLMS update -> FIR.
// Optional latency statistics are built when ANC_SEQ_STATS_EN is defined;
// otherwise max_lat_out is tied to zero.
module anc_sequencer
    import anc_seq_pkg::*;
#(
    parameter int WARMUP_SAMPLES = 64,
    parameter int STAGE_TIMEOUT  = 1024,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sample_pulse_in,
    input  logic             nc_on_in,
    input  logic             freeze_in,
    output logic             lp_start_out,
    input  logic             lp_amb_done_in,
    input  logic             lp_fb_done_in,
    output logic             nlms_start_out,
    input  logic             nlms_done_in,
    output logic             fir_start_out,
    input  logic             fir_done_in,
    output logic             coeff_clear_out,
    output logic             busy_out,
    output logic             warm_out,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] overrun_cnt_out,
    output logic [CNT_W-1:0] timeout_cnt_out,
    output logic [CNT_W-1:0] max_lat_out
);

    localparam int WARM_W = $clog2(WARMUP_SAMPLES + 1);
    localparam int STG_W  = $clog2(STAGE_TIMEOUT);
    localparam logic [STG_W-1:0]  STG_LAST = STG_W'(STAGE_TIMEOUT - 1);
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WARMUP_SAMPLES);

    state_t            state_reg, state_next;
    logic [STG_W-1:0]  stage_cnt_reg;
    logic              amb_reg, amb_next, fb_reg, fb_next;
    logic              clear_pending_reg;
    logic              nc_on_d_reg;
    logic              lp_start_reg, lp_start_next;
    logic              nlms_start_reg, nlms_start_next;
    logic              fir_start_reg, fir_start_next;
    logic              coeff_clear_reg, coeff_clear_next;

    logic              amb_seen, fb_seen, stage_expired, nc_fall;
    logic              accept, warm_inc, warm_clr, overrun_inc, timeout_inc;
    logic [WARM_W-1:0] warm_cnt;

    assign nc_fall       = nc_on_d_reg && !nc_on_in;
    assign amb_seen      = amb_reg || lp_amb_done_in;
    assign fb_seen       = fb_reg || lp_fb_done_in;
    assign stage_expired = (stage_cnt_reg == STG_LAST);

    // Next-state, start pulses, done latches and counter strobes.
    always_comb begin
        state_next       = state_reg;
        lp_start_next    = 1'b0;
        nlms_start_next  = 1'b0;
        fir_start_next   = 1'b0;
        coeff_clear_next = 1'b0;
        amb_next         = amb_reg;
        fb_next          = fb_reg;
        accept           = 1'b0;
        warm_inc         = 1'b0;
        warm_clr         = 1'b0;
        overrun_inc      = 1'b0;
        timeout_inc      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // A pending clear must run before any new sample is started.
                if (clear_pending_reg) begin
                    state_next       = S_CLEAR;
                    coeff_clear_next = 1'b1;
                end else if (sample_pulse_in) begin
                    accept = 1'b1;
                end
            end
            S_LP_WAIT: begin
                overrun_inc = sample_pulse_in;
                amb_next    = amb_seen;
                fb_next     = fb_seen;
                // Decide in the cycle the second done arrives, not one later.
                if (amb_seen && fb_seen) begin
                    if (warm_out && nc_on_in && !freeze_in) begin
                        nlms_start_next = 1'b1;
                        state_next      = S_ADAPT;
                    end else begin
                        fir_start_next = 1'b1;
                        state_next     = S_FILTER;
                    end
                end else if (stage_expired) begin
                    timeout_inc = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_ADAPT: begin
                overrun_inc = sample_pulse_in;
                if (nlms_done_in) begin
                    fir_start_next = 1'b1;
                    state_next     = S_FILTER;
                end else if (stage_expired) begin
                    timeout_inc = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_FILTER: begin
                if (fir_done_in) begin
                    warm_inc = 1'b1;
                    // Back-to-back: a pulse coinciding with completion is taken directly.
                    if (sample_pulse_in && !clear_pending_reg) begin
                        accept = 1'b1;
                    end else begin
                        overrun_inc = sample_pulse_in;
                        state_next  = S_IDLE;
                    end
                end else begin
                    overrun_inc = sample_pulse_in;
                    if (stage_expired) begin
                        timeout_inc = 1'b1;
                        state_next  = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                overrun_inc = sample_pulse_in;
                warm_clr    = 1'b1;
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (accept) begin
            lp_start_next = 1'b1;
            state_next    = S_LP_WAIT;
            amb_next      = 1'b0;
            fb_next       = 1'b0;
        end
    end

    // State, registered pulses, latches and the per-state watchdog.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg       <= S_IDLE;
            stage_cnt_reg   <= '0;
            amb_reg         <= 1'b0;
            fb_reg          <= 1'b0;
            lp_start_reg    <= 1'b0;
            nlms_start_reg  <= 1'b0;
            fir_start_reg   <= 1'b0;
            coeff_clear_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            amb_reg         <= amb_next;
            fb_reg          <= fb_next;
            lp_start_reg    <= lp_start_next;
            nlms_start_reg  <= nlms_start_next;
            fir_start_reg   <= fir_start_next;
            coeff_clear_reg <= coeff_clear_next;
            if (state_next != state_reg) begin
                stage_cnt_reg <= '0;
            end else if (state_reg inside {S_LP_WAIT, S_ADAPT, S_FILTER}) begin
                stage_cnt_reg <= stage_cnt_reg + STG_W'(1);
            end
        end
    end

    // Noise-cancel falling edge arms a clear that runs once back in IDLE.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            nc_on_d_reg       <= 1'b0;
            clear_pending_reg <= 1'b0;
        end else begin
            nc_on_d_reg <= nc_on_in;
            if (nc_fall) begin
                clear_pending_reg <= 1'b1;
            end else if (state_reg == S_CLEAR) begin
                clear_pending_reg <= 1'b0;
            end
        end
    end

    anc_sat_counter #(.W(WARM_W), .MAX(WARM_MAX)) u_warm_cnt (
        .clk   (clk_in),
        .rst_n (rst_in),
        .clr   (warm_clr),
        .inc   (warm_inc),
        .count (warm_cnt)
    );

    // Debug counters: index 0 = overruns, index 1 = timeouts.
    logic [1:0]       dbg_inc;
    logic [CNT_W-1:0] dbg_cnt [2];
    assign dbg_inc = {timeout_inc, overrun_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dbg_cnt
            anc_sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (clk_in),
                .rst_n (rst_in),
                .clr   (1'b0),
                .inc   (dbg_inc[gi]),
                .count (dbg_cnt[gi])
            );
        end
    endgenerate

`ifdef ANC_SEQ_STATS_EN
    logic [CNT_W-1:0] lat_reg, max_lat_reg;
    logic             lat_run_reg;

    // Latency from sample acceptance to FIR done; maximum kept until reset/CLEAR.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lat_reg     <= '0;
            max_lat_reg <= '0;
            lat_run_reg <= 1'b0;
        end else begin
            if (state_reg == S_CLEAR) begin
                max_lat_reg <= '0;
            end
            if (accept) begin
                lat_reg     <= '0;
                lat_run_reg <= 1'b1;
            end else if (lat_run_reg && (lat_reg != '1)) begin
                lat_reg <= lat_reg + CNT_W'(1);
            end
            if ((state_reg == S_FILTER) && fir_done_in && lat_run_reg) begin
                if (lat_reg > max_lat_reg) begin
                    max_lat_reg <= lat_reg;
                end
                if (!accept) begin
                    lat_run_reg <= 1'b0;
                end
            end
            if (timeout_inc) begin
                lat_run_reg <= 1'b0;
            end
        end
    end

    assign max_lat_out = max_lat_reg;
`else
    assign max_lat_out = '0;
`endif

    assign lp_start_out    = lp_start_reg;
    assign nlms_start_out  = nlms_start_reg;
    assign fir_start_out   = fir_start_reg;
    assign coeff_clear_out = coeff_clear_reg;
    assign busy_out        = (state_reg != S_IDLE);
    assign warm_out        = (warm_cnt == WARM_MAX);
    assign state_out       = state_reg;
    assign overrun_cnt_out = dbg_cnt[0];
    assign timeout_cnt_out = dbg_cnt[1];

endmodule
